// File: rtl/freq_counter_mc.sv
`default_nettype none
// ============================================================================
// Module   : freq_counter_mc
// Brief    : Multi-channel period / gated edge-count meter with per-channel
//            circular history and registered readout.
// Revision : 1.0
// ============================================================================
module freq_counter_mc #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 8,
    parameter int GATE_CYCLES = 1000,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int DW = $clog2(DEPTH)
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                mode,
    input  logic                clr,
    input  logic [CHANNELS-1:0] in_wave,
    input  logic [CW-1:0]       rd_ch,
    input  logic [DW-1:0]       rd_idx,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_valid,
    output logic [CHANNELS-1:0] new_sample,
    output logic [CHANNELS-1:0] overflow
);
    localparam int               GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [DW:0]      FILL_FULL = (DW + 1)'(DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, MEAS = 1'b1} state_t;

    logic [CHANNELS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic                mode_q, mode_d;
    logic [GW-1:0]       gate_q, gate_d;
    state_t              state_q  [CHANNELS];
    state_t              state_d  [CHANNELS];
    logic [WIDTH-1:0]    cnt_q    [CHANNELS];
    logic [WIDTH-1:0]    cnt_d    [CHANNELS];
    logic [DW-1:0]       wr_ptr_q [CHANNELS];
    logic [DW-1:0]       wr_ptr_d [CHANNELS];
    logic [DW:0]         fill_q   [CHANNELS];
    logic [DW:0]         fill_d   [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d, new_q, new_d;
    logic [WIDTH-1:0]    rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]    mem_q    [CHANNELS][DEPTH];

    logic [CHANNELS-1:0] rise_w, store_w;
    logic [WIDTH-1:0]    store_val_w [CHANNELS];
    logic                mode_chg_w, gate_end_w;
    logic [DW-1:0]       rd_ptr_w;

    always_comb begin
        sync1_d    = in_wave;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        rise_w     = sync2_q & ~prev_q;
        mode_d     = mode;
        mode_chg_w = (mode != mode_q);
        gate_end_w = mode_q && (gate_q == GATE_LAST);
        gate_d     = (gate_end_w || !mode_q) ? '0 : gate_q + GW'(1);
        ovf_d      = ovf_q;
        store_w    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c]     = state_q[c];
            cnt_d[c]       = cnt_q[c];
            wr_ptr_d[c]    = wr_ptr_q[c];
            fill_d[c]      = fill_q[c];
            store_val_w[c] = cnt_q[c];
            if (!mode_q) begin
                if (state_q[c] == IDLE) begin
                    if (rise_w[c]) begin
                        state_d[c] = MEAS;
                        cnt_d[c]   = CNT_ONE;
                    end
                end else if (rise_w[c]) begin
                    store_w[c] = 1'b1;
                    cnt_d[c]   = CNT_ONE;
                end else if (cnt_q[c] != CNT_MAX) begin
                    cnt_d[c] = cnt_q[c] + CNT_ONE;
                end
            end else begin
                // Window total includes an edge landing on the last gate cycle.
                if (rise_w[c] && (cnt_q[c] != CNT_MAX))
                    cnt_d[c] = cnt_q[c] + CNT_ONE;
                if (gate_end_w) begin
                    store_w[c]     = 1'b1;
                    store_val_w[c] = cnt_d[c];
                    cnt_d[c]       = '0;
                end
            end
            if (store_w[c]) begin
                wr_ptr_d[c] = wr_ptr_q[c] + DW'(1);
                if (fill_q[c] != FILL_FULL)
                    fill_d[c] = fill_q[c] + (DW + 1)'(1);
                if (store_val_w[c] == CNT_MAX)
                    ovf_d[c] = 1'b1;
            end
            if (mode_chg_w) begin
                state_d[c] = IDLE;
                cnt_d[c]   = '0;
            end
            if (clr) begin
                state_d[c]  = IDLE;
                cnt_d[c]    = '0;
                wr_ptr_d[c] = '0;
                fill_d[c]   = '0;
                store_w[c]  = 1'b0;
            end
        end
        if (mode_chg_w || clr)
            gate_d = '0;
        if (clr)
            ovf_d = '0;
        new_d = store_w;
    end

    // Readout sees the history as it stood before any write in the same cycle.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_data_d  = '0;
        rd_ptr_w   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(rd_ch) == c) begin
                rd_ptr_w = wr_ptr_q[c] - DW'(1) - rd_idx;
                if ({1'b0, rd_idx} < fill_q[c]) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem_q[c][rd_ptr_w];
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            mode_q     <= 1'b0;
            gate_q     <= '0;
            ovf_q      <= '0;
            new_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c]  <= IDLE;
                cnt_q[c]    <= '0;
                wr_ptr_q[c] <= '0;
                fill_q[c]   <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            mode_q     <= mode_d;
            gate_q     <= gate_d;
            ovf_q      <= ovf_d;
            new_q      <= new_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c]  <= state_d[c];
                cnt_q[c]    <= cnt_d[c];
                wr_ptr_q[c] <= wr_ptr_d[c];
                fill_q[c]   <= fill_d[c];
            end
        end
    end

    always_ff @(posedge Clock) begin
        for (int c = 0; c < CHANNELS; c++)
            if (store_w[c])
                mem_q[c][wr_ptr_q[c]] <= store_val_w[c];
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign new_sample = new_q;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_counter_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_freq_counter_mc
// Brief    : Randomized bench for freq_counter_mc against a sample-list model.
// Revision : 1.0
// ============================================================================
module tb_freq_counter_mc;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int G  = 1000;

    logic          Clock = 1'b0, nReset = 1'b0, mode = 1'b0, clr = 1'b0;
    logic [CH-1:0] in_wave = '0;
    logic [1:0]    rd_ch = '0;
    logic [2:0]    rd_idx = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [CH-1:0] new_sample, overflow;

    int checks = 0, failures = 0, cyc = 0;

    // Model: newest-first list of expected stored values per channel.
    int            hist [CH][$];
    bit            armed [CH];
    int            last_t [CH];
    int            nsamp [CH];
    int            ns_cnt [CH];
    logic [CH-1:0] ovf_m = '0;
    bit            gated_m = 1'b0;

    bit en [CH];
    bit rnd [CH];
    int next_rise [CH], period [CH], incr [CH], rises [CH], max_rises [CH];
    int hi_left [CH], rise_at [CH];
    int clr_rise = -1, clr_cyc = -1;

    freq_counter_mc #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .GATE_CYCLES(G)) dut (
        .Clock(Clock), .nReset(nReset), .mode(mode), .clr(clr), .in_wave(in_wave),
        .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
        .new_sample(new_sample), .overflow(overflow)
    );

    initial forever #500 Clock = ~Clock;

    initial begin
        #100_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            hist[c].delete();
            armed[c] = 1'b0;
        end
        ovf_m = '0;
    endtask

    task automatic model_rise(input int c);
        int v;
        if (gated_m) return;
        if (armed[c]) begin
            v = cyc - last_t[c];
            if (v > 255) v = 255;
            hist[c].push_front(v);
            nsamp[c]++;
            if (v == 255) ovf_m[c] = 1'b1;
        end
        armed[c]  = 1'b1;
        last_t[c] = cyc;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
        clr = (cyc == clr_cyc);
        for (int c = 0; c < CH; c++)
            ns_cnt[c] += new_sample[c] ? 1 : 0;
        for (int c = 0; c < CH; c++) begin
            if (hi_left[c] > 0) begin
                hi_left[c]--;
                if (hi_left[c] == 0) in_wave[c] = 1'b0;
            end
            if (en[c] && rises[c] < max_rises[c] && cyc >= next_rise[c]) begin
                in_wave[c] = 1'b1;
                hi_left[c] = 3;
                rises[c]++;
                rise_at[c] = cyc;
                if (c == 0 && rises[0] == clr_rise) begin
                    clr_cyc = cyc + 2;  // clr lands on the detection edge
                    model_clear();
                end else begin
                    model_rise(c);
                end
                next_rise[c] = cyc + (rnd[c] ? int'($urandom_range(40, 6)) : period[c]);
                period[c] += incr[c];
            end
        end
    endtask

    task automatic start(input int c, input int dly, input int per, input int inc,
                         input bit r, input int maxr);
        en[c] = 1'b1; next_rise[c] = cyc + dly; period[c] = per; incr[c] = inc;
        rnd[c] = r; rises[c] = 0; max_rises[c] = maxr;
    endtask

    task automatic run_until_done(input int budget);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            tick();
            n++;
            busy = 1'b0;
            for (int c = 0; c < CH; c++)
                if (en[c] && rises[c] < max_rises[c]) busy = 1'b1;
        end
        chk("sched_timeout", 32'(busy), 0);
        repeat (12) tick();
        for (int c = 0; c < CH; c++) en[c] = 1'b0;
    endtask

    task automatic rd(input int c, input int i);
        rd_ch  = 2'(c);
        rd_idx = 3'(i);
        tick();
    endtask

    task automatic read_chk(input int c, input int i);
        bit v;
        rd(c, i);
        v = (i < hist[c].size());
        chk($sformatf("rd_valid c%0d i%0d", c, i), 32'(rd_valid), 32'(v));
        chk($sformatf("rd_data c%0d i%0d", c, i), 32'(rd_data), v ? hist[c][i] : 0);
    endtask

    task automatic check_all();
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < D; i++)
                read_chk(c, i);
        for (int c = 0; c < CH; c++)
            chk($sformatf("new_sample_count c%0d", c), ns_cnt[c], nsamp[c]);
        chk("overflow_model", 32'(overflow), 32'(ovf_m));
    endtask

    task automatic do_reset();
        #200 nReset = 1'b0;
        #10;
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_new_sample", 32'(new_sample), 0);
        chk("rst_overflow", 32'(overflow), 0);
        model_clear();
        #490 nReset = 1'b1;
    endtask

    initial begin
        int n;
        for (int c = 0; c < CH; c++) begin
            armed[c] = 0; last_t[c] = 0; nsamp[c] = 0; ns_cnt[c] = 0; en[c] = 0; rnd[c] = 0;
            next_rise[c] = 0; period[c] = 0; incr[c] = 0; rises[c] = 0; max_rises[c] = 0;
            hi_left[c] = 0; rise_at[c] = 0;
        end
        repeat (3) @(posedge Clock);
        #1;
        chk("init_rd_data", 32'(rd_data), 0);
        chk("init_rd_valid", 32'(rd_valid), 0);
        chk("init_new_sample", 32'(new_sample), 0);
        chk("init_overflow", 32'(overflow), 0);
        nReset = 1'b1;
        repeat (3) tick();

        // Period mode: fixed 18, sweeping 10..19, random, and saturating 300.
        start(0, 5, 18, 0, 1'b0, 4);
        start(1, 7, 10, 1, 1'b0, 11);
        start(2, 3, 0, 0, 1'b1, 30);
        start(3, 9, 300, 0, 1'b0, 4);
        run_until_done(4000);
        rd(0, 0); chk("period18", 32'(rd_data), 18);
        rd(1, 0); chk("wrap_idx0", 32'(rd_data), 19);
        rd(1, 7); chk("wrap_idx7", 32'(rd_data), 12);
        chk("wrap_idx7_valid", 32'(rd_valid), 1);
        rd(3, 0); chk("sat_value", 32'(rd_data), 255);
        chk("sat_overflow", 32'(overflow), 32'b1000);
        check_all();

        // clr on the same edge as a ch0 detection.
        clr_rise = 3;
        start(0, 5, 20, 0, 1'b0, 3);
        run_until_done(300);
        chk("clr_overflow", 32'(overflow), 0);
        check_all();
        clr_rise = -1;
        start(0, 5, 20, 0, 1'b0, 3);
        run_until_done(300);
        rd(0, 0); chk("after_clr_idx0", 32'(rd_data), 20);
        rd(0, 2); chk("after_clr_idx2_valid", 32'(rd_valid), 0);
        check_all();

        // Reset pulse in the middle of a period.
        start(0, 5, 18, 0, 1'b0, 6);
        n = 0;
        while (!(rises[0] == 2 && cyc == rise_at[0] + 8) && n < 500) begin
            tick();
            n++;
        end
        chk("reset_align", 32'(rises[0]), 2);
        do_reset();
        run_until_done(500);
        rd(0, 0); chk("after_rst_idx0", 32'(rd_data), 18);
        rd(0, 3); chk("after_rst_idx3_valid", 32'(rd_valid), 0);
        check_all();

        // Gated mode: ch2 edge every 50 cycles, ch3 idle.
        repeat (5) tick();
        mode = 1'b1;
        gated_m = 1'b1;
        start(2, 10, 50, 0, 1'b0, 1000);
        repeat (2100) tick();
        rd(2, 0); chk("gated_idx0", 32'(rd_data), G / 50);
        rd(2, 1); chk("gated_idx1", 32'(rd_data), G / 50);
        rd(3, 0); chk("gated_idle", 32'(rd_data), 0);
        chk("gated_idle_valid", 32'(rd_valid), 1);
        chk("gated_overflow", 32'(overflow), 32'(ovf_m));
        en[2] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
